// File: rtl/lfsr_prbs_checker.sv
// rtl/lfsr_prbs_checker.sv - self-synchronising PRBS checker with lock/loss FSM and saturating error/bit counters
module lfsr_prbs_checker #(
    parameter int                     LFSR_LENGTH    = 4,
    parameter logic [LFSR_LENGTH-1:0] LFSR_PRIM_POLY = 4'b1101,
    parameter int                     LOCK_THRESHOLD = 8,
    parameter int                     LOSS_THRESHOLD = 4,
    parameter int                     CNT_WIDTH      = 16
) (
    input  logic                 lfsr_clk,
    input  logic                 resetn,
    input  logic                 bit_in,
    input  logic                 bit_vld,
    input  logic                 clr_cnt,
    output logic                 locked,
    output logic                 err_pulse,
    output logic                 lock_lost,
    output logic [CNT_WIDTH-1:0] err_cnt,
    output logic [CNT_WIDTH-1:0] bit_cnt
);

    localparam int SEED_W  = $clog2(LFSR_LENGTH + 1);
    localparam int MATCH_W = $clog2(LOCK_THRESHOLD + 1);
    localparam int MISS_W  = $clog2(LOSS_THRESHOLD + 1);
    // Window bit i holds s[n-1-i]; poly bit i selects the x^(i+1) tap, bit 0 is the implicit x^0 term.
    localparam logic [LFSR_LENGTH-1:0] TAP_MASK = {LFSR_PRIM_POLY[LFSR_LENGTH-1:1], 1'b0};

    typedef enum logic [1:0] {
        ST_SEED,
        ST_HUNT,
        ST_LOCKED
    } state_t;

    state_t                 state_q, state_d;
    logic [LFSR_LENGTH-1:0] window_q, window_d;
    logic [SEED_W-1:0]      seed_cnt_q, seed_cnt_d;
    logic [MATCH_W-1:0]     match_cnt_q, match_cnt_d;
    logic [MISS_W-1:0]      miss_cnt_q, miss_cnt_d;
    logic [CNT_WIDTH-1:0]   err_cnt_q, err_cnt_d;
    logic [CNT_WIDTH-1:0]   bit_cnt_q, bit_cnt_d;
    logic                   locked_q, locked_d;
    logic                   err_pulse_q, err_pulse_d;
    logic                   lock_lost_q, lock_lost_d;

    logic                   pred;
    logic                   err_inc;
    logic                   bit_inc;
    logic [MATCH_W-1:0]     match_inc;
    logic [MISS_W-1:0]      miss_inc;

    assign pred      = ^(window_q & TAP_MASK);
    assign match_inc = match_cnt_q + 1'b1;
    assign miss_inc  = miss_cnt_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        window_d    = window_q;
        seed_cnt_d  = seed_cnt_q;
        match_cnt_d = match_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        locked_d    = locked_q;
        err_pulse_d = 1'b0;
        lock_lost_d = 1'b0;
        err_inc     = 1'b0;
        bit_inc     = 1'b0;

        if (bit_vld) begin
            case (state_q)
                ST_SEED: begin
                    window_d = {window_q[LFSR_LENGTH-2:0], bit_in};
                    if (seed_cnt_q == SEED_W'(LFSR_LENGTH - 1)) begin
                        seed_cnt_d = '0;
                        state_d    = ST_HUNT;
                    end else begin
                        seed_cnt_d = seed_cnt_q + 1'b1;
                    end
                end
                ST_HUNT: begin
                    window_d = {window_q[LFSR_LENGTH-2:0], bit_in};
                    // An all-zero window predicts 0 forever, so it must never count toward lock.
                    if ((bit_in == pred) && (window_q != '0)) begin
                        if (match_inc == MATCH_W'(LOCK_THRESHOLD)) begin
                            match_cnt_d = '0;
                            miss_cnt_d  = '0;
                            locked_d    = 1'b1;
                            state_d     = ST_LOCKED;
                        end else begin
                            match_cnt_d = match_inc;
                        end
                    end else begin
                        match_cnt_d = '0;
                    end
                end
                ST_LOCKED: begin
                    window_d = {window_q[LFSR_LENGTH-2:0], pred};
                    bit_inc  = 1'b1;
                    if (bit_in != pred) begin
                        err_inc     = 1'b1;
                        err_pulse_d = 1'b1;
                        if (miss_inc == MISS_W'(LOSS_THRESHOLD)) begin
                            state_d     = ST_SEED;
                            locked_d    = 1'b0;
                            lock_lost_d = 1'b1;
                            window_d    = '0;
                            seed_cnt_d  = '0;
                            match_cnt_d = '0;
                            miss_cnt_d  = '0;
                        end else begin
                            miss_cnt_d = miss_inc;
                        end
                    end else begin
                        miss_cnt_d = '0;
                    end
                end
                default: begin
                    state_d = ST_SEED;
                end
            endcase
        end

        err_cnt_d = err_cnt_q;
        bit_cnt_d = bit_cnt_q;
        if (clr_cnt) begin
            err_cnt_d = '0;
            bit_cnt_d = '0;
        end else begin
            if (err_inc && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + 1'b1;
            if (bit_inc && (bit_cnt_q != '1)) bit_cnt_d = bit_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge lfsr_clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_SEED;
            window_q    <= '0;
            seed_cnt_q  <= '0;
            match_cnt_q <= '0;
            miss_cnt_q  <= '0;
            err_cnt_q   <= '0;
            bit_cnt_q   <= '0;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
            lock_lost_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            window_q    <= window_d;
            seed_cnt_q  <= seed_cnt_d;
            match_cnt_q <= match_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
            err_cnt_q   <= err_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            locked_q    <= locked_d;
            err_pulse_q <= err_pulse_d;
            lock_lost_q <= lock_lost_d;
        end
    end

    assign locked    = locked_q;
    assign err_pulse = err_pulse_q;
    assign lock_lost = lock_lost_q;
    assign err_cnt   = err_cnt_q;
    assign bit_cnt   = bit_cnt_q;

endmodule

// File: tb/tb_lfsr_prbs_checker.sv
// tb/tb_lfsr_prbs_checker.sv - self-checking bench for lfsr_prbs_checker
module tb_lfsr_prbs_checker;

    localparam int CW  = 8;
    localparam int SAT = 255;

    logic          lfsr_clk = 1'b0;
    logic          resetn   = 1'b0;
    logic          bit_in   = 1'b0;
    logic          bit_vld  = 1'b0;
    logic          clr_cnt  = 1'b0;
    logic          locked;
    logic          err_pulse;
    logic          lock_lost;
    logic [CW-1:0] err_cnt;
    logic [CW-1:0] bit_cnt;

    lfsr_prbs_checker #(
        .LFSR_LENGTH   (4),
        .LFSR_PRIM_POLY(4'b1101),
        .LOCK_THRESHOLD(8),
        .LOSS_THRESHOLD(4),
        .CNT_WIDTH     (CW)
    ) dut (
        .lfsr_clk (lfsr_clk),
        .resetn   (resetn),
        .bit_in   (bit_in),
        .bit_vld  (bit_vld),
        .clr_cnt  (clr_cnt),
        .locked   (locked),
        .err_pulse(err_pulse),
        .lock_lost(lock_lost),
        .err_cnt  (err_cnt),
        .bit_cnt  (bit_cnt)
    );

    always #5 lfsr_clk = ~lfsr_clk;

    typedef struct {
        logic l;
        logic p;
        logic ll;
        int   ee;
        int   eb;
    } exp_t;

    typedef struct {
        logic b;
        logic v;
        logic c;
        exp_t e;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[16];
    logic seq [0:14];
    int   checks = 0;
    int   errors = 0;
    int   pidx   = 0;
    int   e_err  = 0;
    int   e_bit  = 0;

    function automatic int sat(input int x);
        return (x > SAT) ? SAT : x;
    endfunction

    function automatic exp_t mk(input logic l, input logic p, input logic ll);
        exp_t e;
        e.l  = l;
        e.p  = p;
        e.ll = ll;
        e.ee = e_err;
        e.eb = e_bit;
        return e;
    endfunction

    task automatic get_bit(output logic b);
        b    = seq[pidx];
        pidx = (pidx == 14) ? 0 : pidx + 1;
    endtask

    task automatic compare(input string nm, input exp_t e);
        logic [CW-1:0] ee;
        logic [CW-1:0] eb;
        ee = e.ee[CW-1:0];
        eb = e.eb[CW-1:0];
        checks++;
        if (locked !== e.l || err_pulse !== e.p || lock_lost !== e.ll ||
            err_cnt !== ee || bit_cnt !== eb) begin
            errors++;
            $display("FAIL %s: got locked=%0b err_pulse=%0b lock_lost=%0b err_cnt=%0d bit_cnt=%0d, expected locked=%0b err_pulse=%0b lock_lost=%0b err_cnt=%0d bit_cnt=%0d",
                     nm, locked, err_pulse, lock_lost, err_cnt, bit_cnt,
                     e.l, e.p, e.ll, e.ee, e.eb);
        end
    endtask

    task automatic step(input string nm, input logic b, input logic v, input logic c, input exp_t e);
        exp_t got;
        bit_in  = b;
        bit_vld = v;
        clr_cnt = c;
        sb.push_back(e);
        @(posedge lfsr_clk);
        #1;
        got = sb.pop_front();
        compare(nm, got);
    endtask

    task automatic clean_locked(input string nm, input int n);
        logic b;
        for (int i = 0; i < n; i++) begin
            get_bit(b);
            e_bit = sat(e_bit + 1);
            step(nm, b, 1'b1, 1'b0, mk(1'b1, 1'b0, 1'b0));
        end
    endtask

    task automatic bad_locked(input string nm, input logic loss);
        logic b;
        get_bit(b);
        e_err = sat(e_err + 1);
        e_bit = sat(e_bit + 1);
        step(nm, ~b, 1'b1, 1'b0, mk(~loss, 1'b1, loss));
    endtask

    task automatic relock(input string nm);
        logic b;
        for (int i = 0; i < 12; i++) begin
            get_bit(b);
            step(nm, b, 1'b1, 1'b0, mk(i == 11, 1'b0, 1'b0));
        end
    endtask

    // Reset asserted between edges; outputs must clear without waiting for a clock.
    task automatic mid_reset(input string nm);
        #2;
        resetn = 1'b0;
        #1;
        e_err = 0;
        e_bit = 0;
        compare(nm, mk(1'b0, 1'b0, 1'b0));
        @(posedge lfsr_clk);
        #1;
        resetn = 1'b1;
    endtask

    initial begin
        logic b;
        seq = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0,
                1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 16; i++) begin
            get_bit(b);
            vecs[i].b    = b;
            vecs[i].v    = 1'b1;
            vecs[i].c    = 1'b0;
            vecs[i].e.l  = (i >= 11);
            vecs[i].e.p  = 1'b0;
            vecs[i].e.ll = 1'b0;
            vecs[i].e.ee = 0;
            vecs[i].e.eb = (i >= 12) ? i - 11 : 0;
        end

        repeat (2) @(posedge lfsr_clk);
        #1;
        compare("reset_state", mk(1'b0, 1'b0, 1'b0));
        resetn = 1'b1;

        for (int i = 0; i < 16; i++)
            step("clean_lock", vecs[i].b, vecs[i].v, vecs[i].c, vecs[i].e);
        e_bit = 4;
        clean_locked("clean_run", 96);

        bad_locked("single_err", 1'b0);
        clean_locked("after_single_err", 5);

        clean_locked("bit_sat", 200);
        for (int i = 0; i < 260; i++) begin
            bad_locked("err_sat", 1'b0);
            clean_locked("err_sat_gap", 1);
        end

        mid_reset("reset_mid_stream");

        for (int i = 0; i < 200; i++)
            step("stuck0", 1'b0, 1'b1, 1'b0, mk(1'b0, 1'b0, 1'b0));

        mid_reset("reset_after_stuck");
        relock("relock_pre_loss");
        clean_locked("locked_run", 3);
        for (int i = 0; i < 3; i++) bad_locked("miss_below_thr", 1'b0);
        clean_locked("miss_reset", 1);
        for (int i = 0; i < 3; i++) bad_locked("miss_below_thr2", 1'b0);
        clean_locked("locked_run2", 2);
        get_bit(b);
        e_err = 0;
        e_bit = 0;
        step("clr_cnt", b, 1'b1, 1'b1, mk(1'b1, 1'b0, 1'b0));
        for (int i = 0; i < 4; i++) bad_locked("loss", i == 3);
        relock("relock_after_loss");
        clean_locked("after_relock", 3);

        mid_reset("reset_before_toggle");
        for (int i = 0; i < 12; i++) begin
            get_bit(b);
            step("toggle_lock", b, 1'b1, 1'b0, mk(i == 11, 1'b0, 1'b0));
            step("toggle_idle", 1'($urandom_range(0, 1)), 1'b0, 1'b0, mk(i == 11, 1'b0, 1'b0));
        end
        for (int i = 0; i < 3; i++) begin
            clean_locked("toggle_locked", 1);
            step("toggle_idle2", 1'($urandom_range(0, 1)), 1'b0, 1'b0, mk(1'b1, 1'b0, 1'b0));
        end
        get_bit(b);
        e_err = 0;
        e_bit = 0;
        step("clr_with_err", ~b, 1'b1, 1'b1, mk(1'b1, 1'b1, 1'b0));
        step("clr_idle", 1'b0, 1'b0, 1'b0, mk(1'b1, 1'b0, 1'b0));
        clean_locked("after_clr", 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
